// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU and its sequencer.
//   W      data width (matches the 4-bit ALU)
//   NREGS  register file depth (3-bit addresses)
//   ADD..AND opcode encodings, also decoded by the ALU itself
//   state_t sequencer FSM encoding
package alu_pkg;
   localparam int W     = 4;
   localparam int NREGS = 8;
   localparam int AW    = 3;

   localparam logic [2:0] ADD = 3'b000;
   localparam logic [2:0] SUB = 3'b001;
   localparam logic [2:0] MUL = 3'b010;
   localparam logic [2:0] DIV = 3'b011;
   localparam logic [2:0] NOT = 3'b100;
   localparam logic [2:0] XOR = 3'b101;
   localparam logic [2:0] OR  = 3'b110;
   localparam logic [2:0] AND = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 8 x 4-bit register file for the ALU sequencer.
//   clk, rst                    clock, async active-high reset (clears all entries)
//   ld_en, ld_addr, ld_data     external load port
//   wb_en, wb_addr, wb_data     ALU writeback port
//   raddr1/rdata1, raddr2/rdata2 asynchronous read ports
module alu_regfile
   import alu_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [W-1:0]  ld_data,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [W-1:0]  wb_data,
   input  logic [AW-1:0] raddr1,
   output logic [W-1:0]  rdata1,
   input  logic [AW-1:0] raddr2,
   output logic [W-1:0]  rdata2
);

   logic [W-1:0] regs [NREGS];

   // Single write port. Load (IDLE only) and writeback (EXEC only) are
   // mutually exclusive in time, so the select order never matters in use.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_en) begin
         regs[wb_addr] <= wb_data;
      end else if (ld_en) begin
         regs[ld_addr] <= ld_data;
      end
   end

   // No bypass: a load at the accept edge is not seen by that request.
   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller in front of the combinational ALU.
//   clk, rst                         clock, async active-high reset
//   ld_en, ld_addr, ld_data          register load (honoured in IDLE only)
//   in_valid/in_ready, in_op,
//   in_dst, in_src1, in_src2         operation request
//   alu_oc, alu_a, alu_b             registered ALU drive
//   alu_f                            ALU result (combinational from alu_*)
//   out_valid/out_ready, out_data,
//   out_dst, out_dz                  result handshake, dz = divide by zero
// FSM: IDLE (accept) -> EXEC (capture/writeback) -> RESP (hold until ack).
module alu_sequencer
   import alu_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_en,
   input  logic [2:0]    ld_addr,
   input  logic [W-1:0]  ld_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_op,
   input  logic [2:0]    in_dst,
   input  logic [2:0]    in_src1,
   input  logic [2:0]    in_src2,
   output logic [2:0]    alu_oc,
   output logic [W-1:0]  alu_a,
   output logic [W-1:0]  alu_b,
   input  logic [W-1:0]  alu_f,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [2:0]    out_dst,
   output logic          out_dz
);

   state_t       state;
   logic [W-1:0] rd1, rd2;
   logic         div0;
   logic         wb_en;
   logic         ld_we;

   // Divide-by-zero is judged from the registered operands, so it is
   // settled before the EXEC edge that would commit the result.
   assign div0  = (alu_oc == DIV) && (alu_b == '0);
   assign wb_en = (state == EXEC) && !div0;
   assign ld_we = ld_en && (state == IDLE);

   alu_regfile u_rf (
      .clk     (clk),
      .rst     (rst),
      .ld_en   (ld_we),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .wb_en   (wb_en),
      .wb_addr (out_dst),
      .wb_data (alu_f),
      .raddr1  (in_src1),
      .rdata1  (rd1),
      .raddr2  (in_src2),
      .rdata2  (rd2)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         alu_oc   <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         out_data <= '0;
         out_dst  <= '0;
         out_dz   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  alu_oc  <= in_op;
                  alu_a   <= rd1;
                  alu_b   <= rd2;
                  out_dst <= in_dst;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               if (div0) begin
                  out_data <= '1;
                  out_dz   <= 1'b1;
               end else begin
                  out_data <= alu_f;
                  out_dz   <= 1'b0;
               end
               state <= RESP;
            end
            RESP: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake flags come straight from the state register.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == RESP);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       ld_en;
   logic [2:0] ld_addr;
   logic [3:0] ld_data;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op, in_dst, in_src1, in_src2;
   logic [2:0] alu_oc;
   logic [3:0] alu_a, alu_b, alu_f;
   logic       out_valid, out_ready;
   logic [3:0] out_data;
   logic [2:0] out_dst;
   logic       out_dz;

   int n_chk = 0;
   int n_fail = 0;
   int ref_rf [8];

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk(clk), .rst(rst),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2),
      .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_dst(out_dst), .out_dz(out_dz)
   );

   // Mathematical meaning of each opcode on 0..15 values.
   function automatic int op_math(input logic [2:0] op, input int a, input int b);
      case (op)
         ADD:     return (a + b) % 16;
         SUB:     return (a - b + 16) % 16;
         MUL:     return (a * b) % 16;
         DIV:     return (b == 0) ? 10 : a / b;  // stand-in ALU garbage on /0
         NOT:     return 15 - a;
         XOR:     return a ^ b;
         OR:      return a | b;
         default: return a & b;
      endcase
   endfunction

   // Stand-in for the external combinational ALU.
   always_comb begin
      int r;
      r = op_math(alu_oc, int'(alu_a), int'(alu_b));
      alu_f = r[3:0];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model of one operation; optional load at the accept edge.
   task automatic model_op(input logic [2:0] op, dst, s1, s2, input bit ld,
                           input logic [2:0] la, input logic [3:0] lv,
                           output int d, output int dz);
      int a, b;
      a = ref_rf[s1];
      b = ref_rf[s2];
      if (ld) ref_rf[la] = lv;
      if (op == DIV && b == 0) begin
         d = 15; dz = 1;
      end else begin
         d = op_math(op, a, b); dz = 0;
         ref_rf[dst] = d;
      end
   endtask

   // Starts and ends just after a falling edge.
   task automatic do_load(input logic [2:0] a, input logic [3:0] v);
      ld_en = 1'b1; ld_addr = a; ld_data = v;
      @(posedge clk); @(negedge clk);
      ld_en = 1'b0;
      ref_rf[a] = v;
   endtask

   // Issue a request, leave the DUT in RESP, return observed result fields.
   task automatic run_op(input logic [2:0] op, dst, s1, s2, input bit ld,
                         input logic [2:0] la, input logic [3:0] lv,
                         output logic [3:0] d, output logic dz, output logic [2:0] od);
      int n;
      chk("in_ready_before_req", in_ready, 1);
      in_valid = 1'b1; in_op = op; in_dst = dst; in_src1 = s1; in_src2 = s2;
      ld_en = ld; ld_addr = la; ld_data = lv;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; ld_en = 1'b0;
      chk("exec_out_valid", out_valid, 0);
      chk("exec_in_ready", in_ready, 0);
      @(posedge clk); @(negedge clk);
      chk("resp_out_valid", out_valid, 1);
      n = 0;
      while (!out_valid && n < 8) begin
         @(posedge clk); @(negedge clk); n++;
      end
      if (!out_valid) chk("resp_timeout", 0, 1);
      d = out_data; dz = out_dz; od = out_dst;
   endtask

   task automatic ack_resp();
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      chk("ack_in_ready", in_ready, 1);
      chk("ack_out_valid", out_valid, 0);
   endtask

   // Full op with model comparison.
   task automatic op_chk(input string nm, input logic [2:0] op, dst, s1, s2,
                         input bit ld, input logic [2:0] la, input logic [3:0] lv);
      logic [3:0] d; logic dz; logic [2:0] od; int ed, edz;
      model_op(op, dst, s1, s2, ld, la, lv, ed, edz);
      run_op(op, dst, s1, s2, ld, la, lv, d, dz, od);
      chk({nm, "_data"}, d, ed);
      chk({nm, "_dz"}, dz, edz);
      chk({nm, "_dst"}, od, dst);
      ack_resp();
   endtask

   // Non-destructive register read: OR rX = rX | rX.
   task automatic rd_chk(input logic [2:0] r);
      op_chk("rd_reg", OR, r, r, r, 1'b0, 3'd0, 4'd0);
   endtask

   typedef struct {
      logic [2:0] op, dst, s1, s2;
      logic [3:0] d;
      logic       dz;
   } vec_t;

   vec_t tbl [10];

   initial begin
      logic [3:0] d, hd; logic dz, hdz; logic [2:0] od, hod;
      int ed, edz;

      tbl[0] = '{ADD, 3'd3, 3'd1, 3'd2, 4'hE, 1'b0};
      tbl[1] = '{ADD, 3'd4, 3'd3, 3'd1, 4'h7, 1'b0};
      tbl[2] = '{MUL, 3'd6, 3'd1, 3'd2, 4'hD, 1'b0};
      tbl[3] = '{SUB, 3'd7, 3'd2, 3'd1, 4'hC, 1'b0};
      tbl[4] = '{DIV, 3'd5, 3'd1, 3'd0, 4'hF, 1'b1};
      tbl[5] = '{OR,  3'd6, 3'd5, 3'd0, 4'h0, 1'b0};
      tbl[6] = '{DIV, 3'd5, 3'd1, 3'd2, 4'h1, 1'b0};
      tbl[7] = '{NOT, 3'd7, 3'd1, 3'd2, 4'h6, 1'b0};
      tbl[8] = '{XOR, 3'd7, 3'd1, 3'd2, 4'hC, 1'b0};
      tbl[9] = '{AND, 3'd7, 3'd1, 3'd2, 4'h1, 1'b0};

      rst = 1'b1; ld_en = 0; ld_addr = 0; ld_data = 0; in_valid = 0;
      in_op = 0; in_dst = 0; in_src1 = 0; in_src2 = 0; out_ready = 0;
      for (int i = 0; i < 8; i++) ref_rf[i] = 0;

      // Reset values
      @(negedge clk); @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu", {alu_oc, alu_a, alu_b}, 0);
      chk("rst_out", {out_data, out_dst, out_dz}, 0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) rd_chk(3'(i));

      // Asynchronous reset in the middle of a low phase while in RESP
      do_load(3'd1, 4'd9);
      do_load(3'd2, 4'd5);
      run_op(ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 4'd0, d, dz, od);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_in_ready", in_ready, 1);
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_out", {out_data, out_dst, out_dz}, 0);
      chk("async_rst_alu", {alu_oc, alu_a, alu_b}, 0);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 8; i++) ref_rf[i] = 0;
      rd_chk(3'd1); rd_chk(3'd3);

      // Directed table
      do_load(3'd1, 4'd9);
      do_load(3'd2, 4'd5);
      for (int i = 0; i < 10; i++) begin
         model_op(tbl[i].op, tbl[i].dst, tbl[i].s1, tbl[i].s2, 1'b0, 3'd0, 4'd0, ed, edz);
         run_op(tbl[i].op, tbl[i].dst, tbl[i].s1, tbl[i].s2, 1'b0, 3'd0, 4'd0, d, dz, od);
         chk($sformatf("tbl%0d_data", i), d, tbl[i].d);
         chk($sformatf("tbl%0d_dz", i), dz, tbl[i].dz);
         chk($sformatf("tbl%0d_dst", i), od, tbl[i].dst);
         ack_resp();
      end

      // Load and request on the same edge: operands see pre-load contents
      op_chk("ld_same_edge", ADD, 3'd4, 3'd1, 3'd1, 1'b1, 3'd1, 4'd3);
      rd_chk(3'd1);

      // Backpressure: fields hold, requests and loads ignored
      model_op(ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 4'd0, ed, edz);
      run_op(ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 4'd0, hd, hdz, hod);
      chk("bp_data", hd, ed);
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid; in_op = SUB; in_dst = 3'd1; in_src1 = 3'd2; in_src2 = 3'd3;
         ld_en = ~ld_en; ld_addr = 3'd1; ld_data = 4'd0;
         @(posedge clk); @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_hold", {out_data, out_dst, out_dz}, {hd, hod, hdz});
      end
      in_valid = 1'b0; ld_en = 1'b0;
      ack_resp();
      rd_chk(3'd1); rd_chk(3'd2); rd_chk(3'd3);

      // Reset during EXEC: transaction dropped
      in_valid = 1'b1; in_op = ADD; in_dst = 3'd3; in_src1 = 3'd1; in_src2 = 3'd2;
      @(posedge clk);
      #2 rst = 1'b1; in_valid = 1'b0;
      #1;
      chk("exec_rst_out_valid", out_valid, 0);
      chk("exec_rst_in_ready", in_ready, 1);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 8; i++) ref_rf[i] = 0;
      @(negedge clk);
      chk("exec_rst_idle_valid", out_valid, 0);
      rd_chk(3'd3); rd_chk(3'd1);

      // Randomized traffic against the model
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            do_load(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
         end else begin
            logic [2:0] op, dst, s1, s2, la; logic [3:0] lv; bit ld; int wait_n;
            op = 3'($urandom_range(0, 7)); dst = 3'($urandom_range(0, 7));
            s1 = 3'($urandom_range(0, 7)); s2 = 3'($urandom_range(0, 7));
            ld = ($urandom_range(0, 3) == 0);
            la = 3'($urandom_range(0, 7)); lv = 4'($urandom_range(0, 15));
            wait_n = $urandom_range(0, 2);
            model_op(op, dst, s1, s2, ld, la, lv, ed, edz);
            run_op(op, dst, s1, s2, ld, la, lv, d, dz, od);
            chk("rnd_data", d, ed);
            chk("rnd_dz", dz, edz);
            chk("rnd_dst", od, dst);
            for (int k = 0; k < wait_n; k++) begin
               @(posedge clk); @(negedge clk);
            end
            ack_resp();
         end
      end
      for (int i = 0; i < 8; i++) rd_chk(3'(i));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
